// File: rtl/ga_pkg.sv
// ga_pkg: shared defaults and state encoding for the GA fitness datapath.
//   Default parameter values, derived payload widths (SE_LEN, IM_LEN, IND_LEN)
//   and the 3-bit dispatch FSM state encoding.
package ga_pkg;

    localparam int unsigned DEF_NUM_PARTICLE_TYPE = 3;
    localparam int unsigned DEF_DATA_WIDTH        = 4;
    localparam int unsigned DEF_LATTICE_LENGTH    = 11;
    localparam int unsigned DEF_POP_SIZE          = 50;
    localparam int unsigned DEF_ADDR_WIDTH        = 6;
    localparam int unsigned DEF_CNT_WIDTH         = 6;

    // Payload widths for the default configuration
    localparam int unsigned SE_LEN  = DEF_NUM_PARTICLE_TYPE * DEF_DATA_WIDTH;
    localparam int unsigned IM_LEN  = DEF_NUM_PARTICLE_TYPE * DEF_NUM_PARTICLE_TYPE * DEF_DATA_WIDTH;
    localparam int unsigned IND_LEN = DEF_LATTICE_LENGTH * DEF_DATA_WIDTH;

    // Dispatch FSM encoding
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_ISSUE = 3'd2;
    localparam logic [2:0] ST_DRAIN = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

endpackage

// File: rtl/dispatch_result_counter.sv
// dispatch_result_counter: saturating count of evaluator results for one batch,
// plus the drain-complete flag and (optionally) the drain watchdog.
//   Macro FITNESS_DISPATCH_TIMEOUT_EN adds the watchdog and the drain_i/expire_o ports.
// Ports:
//   clk_i, rst_i  : clock, synchronous active-high reset
//   clr_i         : clear count (batch accept)
//   cnt_en_i      : results are counted only while high (LOAD/ISSUE/DRAIN)
//   valid_i       : evaluator result valid
//   drain_i       : FSM is in DRAIN (watchdog build only)
//   done_o        : registered, count has reached POP_SIZE
//   expire_o      : registered, watchdog hit its limit (watchdog build only)
module dispatch_result_counter
    import ga_pkg::*;
#(
    parameter int unsigned POP_SIZE  = DEF_POP_SIZE,
    parameter int unsigned CNT_WIDTH = DEF_CNT_WIDTH
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic cnt_en_i,
    input  logic valid_i,
`ifdef FITNESS_DISPATCH_TIMEOUT_EN
    input  logic drain_i,
    output logic expire_o,
`endif
    output logic done_o
);

    logic [CNT_WIDTH-1:0] r_cnt;
    logic [CNT_WIDTH-1:0] w_cnt_nxt;
    logic                 r_done;

    // Saturating result count; surplus valids are dropped
    always_comb begin
        w_cnt_nxt = r_cnt;
        if (clr_i) begin
            w_cnt_nxt = '0;
        end else if (cnt_en_i && valid_i && (r_cnt != CNT_WIDTH'(POP_SIZE))) begin
            w_cnt_nxt = r_cnt + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt  <= '0;
            r_done <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_nxt;
            r_done <= (w_cnt_nxt == CNT_WIDTH'(POP_SIZE));
        end
    end

    assign done_o = r_done;

`ifdef FITNESS_DISPATCH_TIMEOUT_EN
    localparam int unsigned WD_WIDTH = 16;
    localparam int unsigned WD_LIMIT = 1023;

    logic [WD_WIDTH-1:0] r_wd;
    logic [WD_WIDTH-1:0] w_wd_nxt;
    logic                r_expire;

    // Idle-cycle counter: runs only in DRAIN, restarts on every result
    always_comb begin
        w_wd_nxt = '0;
        if (drain_i && !valid_i) begin
            w_wd_nxt = (r_wd == '1) ? r_wd : (r_wd + WD_WIDTH'(1));
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wd     <= '0;
            r_expire <= 1'b0;
        end else begin
            r_wd     <= w_wd_nxt;
            r_expire <= drain_i && (w_wd_nxt == WD_WIDTH'(WD_LIMIT));
        end
    end

    assign expire_o = r_expire;
`endif

endmodule

// File: rtl/fitness_dispatch.sv
// fitness_dispatch: issue-side companion of the fitness evaluator.
//   On start, loads self-energy / interaction config into the evaluator
//   (one-cycle set_data_o), streams POP_SIZE individuals from the selected
//   population buffer, counts results and pulses batch_done_o.
//   Macro FITNESS_DISPATCH_TIMEOUT_EN adds a DRAIN watchdog and timeout_o.
// Ports:
//   clk_i, rst_i                      : clock, synchronous active-high reset
//   start_i, buf_sel_i                : batch request and buffer select (IDLE only)
//   se_cfg_i, im_cfg_i                : evaluator configuration
//   pop_rd_en_o/addr_o/buf_o          : population memory read request
//   pop_rd_data_i                     : read data, one cycle after pop_rd_en_o
//   set_data_o, self_energy_vec_o,
//   interact_matrix_o                 : evaluator configuration load
//   individual_vec_o, in_valid_o,
//   ind_idx_o                         : individual stream to evaluator
//   eval_out_valid_i                  : evaluator result valid
//   busy_o, batch_done_o, timeout_o   : status to GA controller
module fitness_dispatch
    import ga_pkg::*;
#(
    parameter int unsigned NUM_PARTICLE_TYPE = DEF_NUM_PARTICLE_TYPE,
    parameter int unsigned DATA_WIDTH        = DEF_DATA_WIDTH,
    parameter int unsigned LATTICE_LENGTH    = DEF_LATTICE_LENGTH,
    parameter int unsigned POP_SIZE          = DEF_POP_SIZE,
    parameter int unsigned ADDR_WIDTH        = DEF_ADDR_WIDTH,
    parameter int unsigned CNT_WIDTH         = DEF_CNT_WIDTH
) (
    input  logic                                                  clk_i,
    input  logic                                                  rst_i,
    input  logic                                                  start_i,
    input  logic                                                  buf_sel_i,
    input  logic [NUM_PARTICLE_TYPE*DATA_WIDTH-1:0]               se_cfg_i,
    input  logic [NUM_PARTICLE_TYPE*NUM_PARTICLE_TYPE*DATA_WIDTH-1:0] im_cfg_i,
    output logic                                                  pop_rd_en_o,
    output logic [ADDR_WIDTH-1:0]                                 pop_rd_addr_o,
    output logic                                                  pop_rd_buf_o,
    input  logic [LATTICE_LENGTH*DATA_WIDTH-1:0]                  pop_rd_data_i,
    output logic                                                  set_data_o,
    output logic [NUM_PARTICLE_TYPE*DATA_WIDTH-1:0]               self_energy_vec_o,
    output logic [NUM_PARTICLE_TYPE*NUM_PARTICLE_TYPE*DATA_WIDTH-1:0] interact_matrix_o,
    output logic [LATTICE_LENGTH*DATA_WIDTH-1:0]                  individual_vec_o,
    output logic                                                  in_valid_o,
    output logic                                                  ind_idx_o,
    input  logic                                                  eval_out_valid_i,
    output logic                                                  busy_o,
`ifdef FITNESS_DISPATCH_TIMEOUT_EN
    output logic                                                  timeout_o,
`endif
    output logic                                                  batch_done_o
);

    localparam int unsigned SE_W  = NUM_PARTICLE_TYPE * DATA_WIDTH;
    localparam int unsigned IM_W  = NUM_PARTICLE_TYPE * NUM_PARTICLE_TYPE * DATA_WIDTH;
    localparam int unsigned IND_W = LATTICE_LENGTH * DATA_WIDTH;

    logic [2:0]            r_state;
    logic [2:0]            w_state_nxt;
    logic                  w_accept;
    logic                  w_last_rd;
    logic                  w_cnt_en;
    logic                  w_drain_done;
    logic                  w_wd_expire;

    logic                  r_set_data;
    logic [SE_W-1:0]       r_se;
    logic [IM_W-1:0]       r_im;
    logic                  r_buf;
    logic                  r_rd_en;
    logic [ADDR_WIDTH-1:0] r_rd_addr;
    logic                  r_rd_pend;
    logic                  r_in_valid;
    logic [IND_W-1:0]      r_ind;
    logic                  r_ind_idx;
    logic                  r_busy;
    logic                  r_batch_done;

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_last_rd   = (r_rd_addr == ADDR_WIDTH'(POP_SIZE - 1));
        case (r_state)
            ST_IDLE: begin
                if (start_i) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_LOAD:  w_state_nxt = ST_ISSUE;
            ST_ISSUE: if (w_last_rd) w_state_nxt = ST_DRAIN;
            ST_DRAIN: if (w_drain_done || w_wd_expire) w_state_nxt = ST_DONE;
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_cnt_en = (r_state == ST_LOAD) || (r_state == ST_ISSUE) || (r_state == ST_DRAIN);

    // Registered outputs; read-side outputs track the state being entered
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_set_data   <= 1'b0;
            r_se         <= '0;
            r_im         <= '0;
            r_buf        <= 1'b0;
            r_rd_en      <= 1'b0;
            r_rd_addr    <= '0;
            r_rd_pend    <= 1'b0;
            r_in_valid   <= 1'b0;
            r_ind        <= '0;
            r_ind_idx    <= 1'b0;
            r_busy       <= 1'b0;
            r_batch_done <= 1'b0;
        end else begin
            r_set_data <= w_accept;
            if (w_accept) begin
                r_se  <= se_cfg_i;
                r_im  <= im_cfg_i;
                r_buf <= buf_sel_i;
            end
            r_rd_en <= (w_state_nxt == ST_LOAD) || (w_state_nxt == ST_ISSUE);
            if (w_accept) begin
                r_rd_addr <= '0;
            end else if ((r_state == ST_LOAD) || ((r_state == ST_ISSUE) && !w_last_rd)) begin
                r_rd_addr <= r_rd_addr + ADDR_WIDTH'(1);
            end
            // Memory returns data one cycle after the strobe; register it once more
            r_rd_pend  <= r_rd_en;
            r_in_valid <= r_rd_pend;
            if (r_rd_pend) begin
                r_ind <= pop_rd_data_i;
            end
            r_ind_idx    <= r_rd_pend & r_buf;
            r_busy       <= (w_state_nxt != ST_IDLE);
            r_batch_done <= (w_state_nxt == ST_DONE);
        end
    end

    dispatch_result_counter #(
        .POP_SIZE  (POP_SIZE),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_result_counter (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clr_i    (w_accept),
        .cnt_en_i (w_cnt_en),
        .valid_i  (eval_out_valid_i),
`ifdef FITNESS_DISPATCH_TIMEOUT_EN
        .drain_i  (r_state == ST_DRAIN),
        .expire_o (w_wd_expire),
`endif
        .done_o   (w_drain_done)
    );

`ifdef FITNESS_DISPATCH_TIMEOUT_EN
    logic r_timeout;

    // Flags a batch closed by the watchdog rather than by a full result count
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= (r_state == ST_DRAIN) && w_wd_expire && !w_drain_done;
        end
    end

    assign timeout_o = r_timeout;
`else
    assign w_wd_expire = 1'b0;
`endif

    assign set_data_o        = r_set_data;
    assign self_energy_vec_o = r_se;
    assign interact_matrix_o = r_im;
    assign pop_rd_en_o       = r_rd_en;
    assign pop_rd_addr_o     = r_rd_addr;
    assign pop_rd_buf_o      = r_buf;
    assign individual_vec_o  = r_ind;
    assign in_valid_o        = r_in_valid;
    assign ind_idx_o         = r_ind_idx;
    assign busy_o            = r_busy;
    assign batch_done_o      = r_batch_done;

endmodule

// File: tb/tb_fitness_dispatch.sv
// tb_fitness_dispatch: directed self-checking bench for fitness_dispatch with
// POP_SIZE=4. Population memory model returns buf1: 0xA+addr, buf0: 0x1+addr.
module tb_fitness_dispatch;
    import ga_pkg::*;

    localparam int unsigned P  = 4;
    localparam int unsigned AW = 2;
    localparam int unsigned CW = 3;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic               buf_sel;
    logic [SE_LEN-1:0]  se_cfg;
    logic [IM_LEN-1:0]  im_cfg;
    logic               pop_rd_en_o;
    logic [AW-1:0]      pop_rd_addr_o;
    logic               pop_rd_buf_o;
    logic [IND_LEN-1:0] pop_rd_data_i = '0;
    logic               set_data_o;
    logic [SE_LEN-1:0]  self_energy_vec_o;
    logic [IM_LEN-1:0]  interact_matrix_o;
    logic [IND_LEN-1:0] individual_vec_o;
    logic               in_valid_o;
    logic               ind_idx_o;
    logic               eval;
    logic               busy_o;
    logic               batch_done_o;
`ifdef FITNESS_DISPATCH_TIMEOUT_EN
    logic               timeout_o;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    fitness_dispatch #(
        .POP_SIZE   (P),
        .ADDR_WIDTH (AW),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .start_i           (start),
        .buf_sel_i         (buf_sel),
        .se_cfg_i          (se_cfg),
        .im_cfg_i          (im_cfg),
        .pop_rd_en_o       (pop_rd_en_o),
        .pop_rd_addr_o     (pop_rd_addr_o),
        .pop_rd_buf_o      (pop_rd_buf_o),
        .pop_rd_data_i     (pop_rd_data_i),
        .set_data_o        (set_data_o),
        .self_energy_vec_o (self_energy_vec_o),
        .interact_matrix_o (interact_matrix_o),
        .individual_vec_o  (individual_vec_o),
        .in_valid_o        (in_valid_o),
        .ind_idx_o         (ind_idx_o),
        .eval_out_valid_i  (eval),
        .busy_o            (busy_o),
`ifdef FITNESS_DISPATCH_TIMEOUT_EN
        .timeout_o         (timeout_o),
`endif
        .batch_done_o      (batch_done_o)
    );

    // Population memory: one-cycle read latency
    always @(posedge clk) begin
        if (pop_rd_en_o) begin
            pop_rd_data_i <= (pop_rd_buf_o ? IND_LEN'(4'hA) : IND_LEN'(4'h1)) + IND_LEN'(pop_rd_addr_o);
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string pfx);
        check({pfx, " set_data"},   64'(set_data_o),        64'd0);
        check({pfx, " rd_en"},      64'(pop_rd_en_o),       64'd0);
        check({pfx, " rd_addr"},    64'(pop_rd_addr_o),     64'd0);
        check({pfx, " rd_buf"},     64'(pop_rd_buf_o),      64'd0);
        check({pfx, " se"},         64'(self_energy_vec_o), 64'd0);
        check({pfx, " im"},         64'(interact_matrix_o), 64'd0);
        check({pfx, " ind"},        64'(individual_vec_o),  64'd0);
        check({pfx, " in_valid"},   64'(in_valid_o),        64'd0);
        check({pfx, " ind_idx"},    64'(ind_idx_o),         64'd0);
        check({pfx, " busy"},       64'(busy_o),            64'd0);
        check({pfx, " batch_done"}, 64'(batch_done_o),      64'd0);
    endtask

    // Runs the evaluator as an echo of in_valid_o (first n_res individuals only)
    // until batch_done_o or the cycle limit.
    task automatic run_batch(input int limit, input int n_res, output int nset, output bit seen,
                             output logic [IND_LEN-1:0] first_ind, output logic first_idx);
        int given;
        bit got_first;
        nset      = 0;
        seen      = 1'b0;
        given     = 0;
        got_first = 1'b0;
        first_ind = '0;
        first_idx = 1'b0;
        for (int i = 0; i < limit; i++) begin
            tick();
            if (set_data_o) nset++;
            if (in_valid_o && !got_first) begin
                got_first = 1'b1;
                first_ind = individual_vec_o;
                first_idx = ind_idx_o;
            end
            if (batch_done_o) begin
                seen = 1'b1;
                break;
            end
            if (in_valid_o && (given < n_res)) begin
                eval = 1'b1;
                given++;
            end else begin
                eval = 1'b0;
            end
        end
        eval = 1'b0;
    endtask

    initial begin
        bit exp_en [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        bit exp_iv [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [IND_LEN-1:0] exp_ind [6] = '{44'h0, 44'hA, 44'hB, 44'hC, 44'hD, 44'hD};
        int nset;
        int pulses;
        bit seen;
        logic [IND_LEN-1:0] f_ind;
        logic f_idx;

        rst = 1'b1; start = 1'b0; buf_sel = 1'b0; se_cfg = '0; im_cfg = '0; eval = 1'b0;
        repeat (3) tick();
        check_all_zero("reset");
        rst = 1'b0;
        tick();
        check("idle busy", 64'(busy_o), 64'd0);

        // Batch 1: buffer 1, config captured on accept
        buf_sel = 1'b1; se_cfg = 12'h321; im_cfg = 36'h9_8765_4321; start = 1'b1;
        tick();
        start = 1'b0; buf_sel = 1'b0; se_cfg = 12'hFFF; im_cfg = '1;
        check("b1 set_data", 64'(set_data_o), 64'd1);
        check("b1 rd_en C1", 64'(pop_rd_en_o), 64'd1);
        check("b1 addr C1", 64'(pop_rd_addr_o), 64'd0);
        check("b1 rd_buf", 64'(pop_rd_buf_o), 64'd1);
        check("b1 busy", 64'(busy_o), 64'd1);
        check("b1 se", 64'(self_energy_vec_o), 64'h321);
        check("b1 im", 64'(interact_matrix_o), 64'h9_8765_4321);
        check("b1 in_valid C1", 64'(in_valid_o), 64'd0);
        for (int k = 0; k < 6; k++) begin
            tick();
            check($sformatf("b1 set_data C%0d", k + 2), 64'(set_data_o), 64'd0);
            check($sformatf("b1 rd_en C%0d", k + 2), 64'(pop_rd_en_o), 64'(exp_en[k]));
            if (exp_en[k]) check($sformatf("b1 addr C%0d", k + 2), 64'(pop_rd_addr_o), 64'(k + 1));
            if (exp_en[k]) check($sformatf("b1 rd_buf C%0d", k + 2), 64'(pop_rd_buf_o), 64'd1);
            check($sformatf("b1 in_valid C%0d", k + 2), 64'(in_valid_o), 64'(exp_iv[k]));
            if (k > 0) check($sformatf("b1 ind C%0d", k + 2), 64'(individual_vec_o), 64'(exp_ind[k]));
            if (exp_iv[k]) check($sformatf("b1 ind_idx C%0d", k + 2), 64'(ind_idx_o), 64'd1);
        end
        // Four results returned while draining
        for (int k = 0; k < 4; k++) begin
            eval = 1'b1;
            tick();
            check("b1 no early done", 64'(batch_done_o), 64'd0);
        end
        eval = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (batch_done_o) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        check("b1 batch_done seen", 64'(seen), 64'd1);
        check("b1 busy in DONE", 64'(busy_o), 64'd1);
        tick();
        check("b1 done one cycle", 64'(batch_done_o), 64'd0);
        check("b1 busy falls", 64'(busy_o), 64'd0);
        check("b1 se stable", 64'(self_energy_vec_o), 64'h321);
        pulses = 0;
        repeat (5) begin
            tick();
            if (batch_done_o) pulses++;
        end
        check("b1 no extra done", 64'(pulses), 64'd0);

        // Batch 2: start held high; exactly one batch, re-accept right after DONE
        buf_sel = 1'b0; se_cfg = 12'h0AB; start = 1'b1;
        run_batch(40, 4, nset, seen, f_ind, f_idx);
        check("b2 batch_done seen", 64'(seen), 64'd1);
        check("b2 one set_data", 64'(nset), 64'd1);
        check("b2 first ind", 64'(f_ind), 64'h1);
        check("b2 ind_idx", 64'(f_idx), 64'd0);
        check("b2 se", 64'(self_energy_vec_o), 64'h0AB);
        tick();
        check("b2 idle busy", 64'(busy_o), 64'd0);
        check("b2 idle set_data", 64'(set_data_o), 64'd0);
        tick();
        start = 1'b0;
        check("b3 accepted after DONE", 64'(set_data_o), 64'd1);
        run_batch(40, 4, nset, seen, f_ind, f_idx);
        check("b3 batch_done seen", 64'(seen), 64'd1);
        check("b3 first ind", 64'(f_ind), 64'h1);
        repeat (2) tick();

        // Reset in ISSUE after two reads
        buf_sel = 1'b1; se_cfg = 12'h555; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("rst addr before", 64'(pop_rd_addr_o), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_all_zero("midrst");
        pulses = 0;
        repeat (6) begin
            tick();
            if (batch_done_o || busy_o || in_valid_o) pulses++;
        end
        check("midrst quiet", 64'(pulses), 64'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        run_batch(40, 4, nset, seen, f_ind, f_idx);
        check("post-rst done", 64'(seen), 64'd1);
        check("post-rst first ind", 64'(f_ind), 64'hA);
        check("post-rst ind_idx", 64'(f_idx), 64'd1);
        repeat (2) tick();

        // Only 3 of 4 results: stays in DRAIN
        buf_sel = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        run_batch(60, 3, nset, seen, f_ind, f_idx);
        check("short no done", 64'(seen), 64'd0);
        check("short busy", 64'(busy_o), 64'd1);
`ifdef FITNESS_DISPATCH_TIMEOUT_EN
        seen = 1'b0;
        for (int i = 0; i < 1200; i++) begin
            tick();
            if (batch_done_o) begin
                seen = 1'b1;
                break;
            end
        end
        check("timeout done", 64'(seen), 64'd1);
        check("timeout flag", 64'(timeout_o), 64'd1);
        tick();
        check("timeout flag pulse", 64'(timeout_o), 64'd0);
        check("timeout busy", 64'(busy_o), 64'd0);
`else
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("short rst busy", 64'(busy_o), 64'd0);
`endif
        repeat (2) tick();

        // Six result pulses for four individuals: single batch_done
        buf_sel = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        pulses = 0;
        for (int k = 0; k < 6; k++) begin
            eval = 1'b1;
            tick();
            if (batch_done_o) pulses++;
        end
        eval = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (batch_done_o) pulses++;
        end
        check("sat single done", 64'(pulses), 64'd1);
        check("sat idle", 64'(busy_o), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
